// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit packer.
// State encoding, header length, checksum substitution and header byte selection.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    CSUM_WAIT = 3'd2,
    HDR       = 3'd3,
    PAY       = 3'd4
  } udp_state_t;

  localparam int          UDP_HDR_LEN   = 8;
  localparam int          PAY_W         = 8;
  localparam logic [15:0] CSUM_ZERO_SUB = 16'hFFFF;

  // Header byte idx of the 8-byte UDP header, each field MSB first.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] src,
                                          input logic [15:0] dst,
                                          input logic [15:0] len,
                                          input logic [15:0] csum);
    logic [7:0] b;
    case (idx)
      3'd0:    b = src[15:8];
      3'd1:    b = src[7:0];
      3'd2:    b = dst[15:8];
      3'd3:    b = dst[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      3'd6:    b = csum[15:8];
      default: b = csum[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_payload_fifo.sv
// Single-clock payload buffer, 2^DEPTH_LOG2 bytes, show-ahead read port and occupancy count.
module udp_payload_fifo
  import udp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PAY_W-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [PAY_W-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [PAY_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == FULL_CNT);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_tx_packer.sv
// Buffers a UDP payload, then emits the 8-byte header and payload under a ready/valid handshake.
// Define UDP_CSUM_EN to wait CSUM_LAT cycles for udp_check_sum; otherwise the checksum field is zero.
//
//   state     | meaning
//   IDLE      | waiting for the first payload byte
//   LOAD      | writing payload bytes into the buffer
//   CSUM_WAIT | letting the checksum stage settle (UDP_CSUM_EN only)
//   HDR       | emitting header bytes 0..7
//   PAY       | emitting buffered payload bytes
module udp_tx_packer
  import udp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11,
  parameter int CSUM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] port_src,
  input  logic [15:0] port_dst,
  input  logic [7:0]  udp_data,
  input  logic        udp_data_en,
  input  logic        udp_data_last,
  input  logic [15:0] udp_check_sum,
  output logic [15:0] udp_len,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        ovf_err
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  udp_state_t            state;
  logic [DEPTH_LOG2:0]   pay_cnt;
  logic [2:0]            hdr_idx;
  logic [15:0]           src_q;
  logic [15:0]           dst_q;
  logic [15:0]           csum_q;
  logic                  fifo_wr_en;
  logic                  fifo_rd_en;
  logic [7:0]            fifo_rd_data;
  logic [DEPTH_LOG2:0]   fifo_cnt;
  logic                  fifo_full;

`ifdef UDP_CSUM_EN
  localparam int TW = (CSUM_LAT > 1) ? $clog2(CSUM_LAT + 1) : 1;
  logic [TW-1:0] timer;
`else
  logic unused_csum;
  assign unused_csum = ^{udp_check_sum, 32'(CSUM_LAT)};
  assign csum_q      = 16'h0000;
`endif

  // Zero only while idle and empty, so reset and post-frame both read as 0.
  assign udp_len = (pay_cnt == '0) ? 16'h0000 : 16'(pay_cnt) + 16'(UDP_HDR_LEN);

  assign fifo_wr_en = udp_data_en && ((state == IDLE) || ((state == LOAD) && !fifo_full));
  assign fifo_rd_en = tx_en && tx_ready &&
                      (((state == HDR) && (hdr_idx == 3'd7)) || ((state == PAY) && !tx_last));

  udp_payload_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr_en),
    .wr_data (udp_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .count   (fifo_cnt),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pay_cnt <= '0;
      hdr_idx <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      tx_data <= '0;
      tx_en   <= 1'b0;
      tx_last <= 1'b0;
      busy    <= 1'b0;
      ovf_err <= 1'b0;
`ifdef UDP_CSUM_EN
      timer   <= '0;
      csum_q  <= '0;
`endif
    end else begin
      ovf_err <= 1'b0;
      case (state)
        IDLE: begin
          if (udp_data_en) begin
            src_q   <= port_src;
            dst_q   <= port_dst;
            pay_cnt <= CNT_ONE;
            busy    <= 1'b1;
            if (udp_data_last) begin
`ifdef UDP_CSUM_EN
              state <= CSUM_WAIT;
              timer <= TW'(CSUM_LAT);
`else
              state   <= HDR;
              hdr_idx <= '0;
              tx_en   <= 1'b1;
              tx_data <= port_src[15:8];
`endif
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (udp_data_en) begin
            if (fifo_full) ovf_err <= 1'b1;
            else           pay_cnt <= pay_cnt + CNT_ONE;
            if (udp_data_last) begin
`ifdef UDP_CSUM_EN
              state <= CSUM_WAIT;
              timer <= TW'(CSUM_LAT);
`else
              state   <= HDR;
              hdr_idx <= '0;
              tx_en   <= 1'b1;
              tx_data <= src_q[15:8];
`endif
            end
          end
        end

`ifdef UDP_CSUM_EN
        CSUM_WAIT: begin
          if (udp_data_en) ovf_err <= 1'b1;
          // Terminal at 1 so the first header byte lands CSUM_LAT+1 cycles after the last input.
          if (timer <= TW'(1)) begin
            csum_q  <= (udp_check_sum == 16'h0000) ? CSUM_ZERO_SUB : udp_check_sum;
            state   <= HDR;
            hdr_idx <= '0;
            tx_en   <= 1'b1;
            tx_data <= src_q[15:8];
          end else begin
            timer <= timer - TW'(1);
          end
        end
`endif

        HDR: begin
          if (udp_data_en) ovf_err <= 1'b1;
          if (tx_ready) begin
            if (hdr_idx == 3'd7) begin
              state   <= PAY;
              hdr_idx <= '0;
              tx_data <= fifo_rd_data;
              tx_last <= (fifo_cnt == CNT_ONE);
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
              tx_data <= hdr_byte(hdr_idx + 3'd1, src_q, dst_q, udp_len, csum_q);
            end
          end
        end

        PAY: begin
          if (udp_data_en) ovf_err <= 1'b1;
          if (tx_ready) begin
            if (tx_last) begin
              state   <= IDLE;
              tx_en   <= 1'b0;
              tx_last <= 1'b0;
              tx_data <= '0;
              busy    <= 1'b0;
              pay_cnt <= '0;
            end else begin
              tx_data <= fifo_rd_data;
              tx_last <= (fifo_cnt == CNT_ONE);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_packer.sv
// Self-checking bench for udp_tx_packer: queue-based segment model, per-cycle compare, directed and random frames.
module tb_udp_tx_packer;
  import udp_pkg::*;

  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;
  localparam int LAT   = 2;
`ifdef UDP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] port_src = '0, port_dst = '0, udp_check_sum = '0;
  logic [7:0]  udp_data = '0;
  logic        udp_data_en = 1'b0, udp_data_last = 1'b0, tx_ready = 1'b1;
  logic [15:0] udp_len;
  logic [7:0]  tx_data;
  logic        tx_en, tx_last, busy, ovf_err;

  udp_tx_packer #(.DEPTH_LOG2(DL2), .CSUM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .port_src(port_src), .port_dst(port_dst),
    .udp_data(udp_data), .udp_data_en(udp_data_en), .udp_data_last(udp_data_last),
    .udp_check_sum(udp_check_sum), .udp_len(udp_len), .tx_data(tx_data),
    .tx_en(tx_en), .tx_last(tx_last), .tx_ready(tx_ready), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0, n_fail = 0;
  int          ovf_seen = 0, exp_ovf = 0, exp_first_cyc = 0;
  int          ready_mode = 0;
  logic [15:0] exp_len = '0;
  logic [7:0]  exp_q[$];
  bit          exp_l[$];
  logic [7:0]  got[$];
  logic [7:0]  pay_in[$];
  bit          first_seen = 1'b1, prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: every transfer is checked against the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_en", tx_en, 1);
        check("hold_data", tx_data, prev_data);
        check("hold_last", tx_last, prev_last);
      end
      if (tx_en && !first_seen) begin
        first_seen = 1'b1;
        check("first_hdr_latency", cyc, exp_first_cyc);
      end
      if (tx_en) check("busy_during_tx", busy, 1);
      if (tx_en && tx_ready) begin
        check("tx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("tx_data", tx_data, exp_q.pop_front());
          check("tx_last", tx_last, exp_l.pop_front());
          check("udp_len", udp_len, exp_len);
        end
        got.push_back(tx_data);
      end
      prev_stall = tx_en && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
      if (ovf_err) ovf_seen++;
    end
  end

  task automatic load_frame(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] cs, input bit stray, input bit gaps);
    int n, kept;
    logic [15:0] len, csf;
    logic [15:0] fld [4];
    n    = pay_in.size();
    kept = (n > DEPTH) ? DEPTH : n;
    len  = 16'(UDP_HDR_LEN + kept);
    csf  = CSUM_ON ? ((cs == 16'h0) ? 16'hFFFF : cs) : 16'h0000;
    fld[0] = src; fld[1] = dst; fld[2] = len; fld[3] = csf;
    got.delete();
    first_seen = 1'b0;
    exp_len    = len;
    exp_ovf    = ovf_seen + (n - kept) + (stray ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(fld[i][15:8]); exp_l.push_back(1'b0);
      exp_q.push_back(fld[i][7:0]);  exp_l.push_back(1'b0);
    end
    for (int i = 0; i < kept; i++) begin
      exp_q.push_back(pay_in[i]); exp_l.push_back(i == kept - 1);
    end
    @(posedge clk); #1;
    port_src = src; port_dst = dst; udp_check_sum = cs;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 1)) begin
          udp_data_en = 1'b0;
          @(posedge clk); #1;
        end
      end
      udp_data_en = 1'b1; udp_data = pay_in[i]; udp_data_last = (i == n - 1);
      if (i == n - 1) exp_first_cyc = cyc + 1 + (CSUM_ON ? LAT : 0);
      @(posedge clk); #1;
      if (i == 0 && gaps) begin
        port_src = 16'($urandom); port_dst = 16'($urandom);
      end
    end
    udp_data_en = 1'b0; udp_data_last = 1'b0;
    if (stray) begin
      udp_data_en = 1'b1; udp_data = 8'($urandom);
      @(posedge clk); #1;
      udp_data_en = 1'b0;
    end
  endtask

  task automatic wait_frame();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk); k++;
    end
    check("frame_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("busy_after", busy, 0);
    check("len_after", udp_len, 0);
    check("tx_en_after", tx_en, 0);
    check("ovf_count", ovf_seen, exp_ovf);
    exp_q.delete(); exp_l.delete();
  endtask

  task automatic rand_payload(input int n);
    pay_in.delete();
    for (int i = 0; i < n; i++) pay_in.push_back(8'($urandom));
  endtask

  logic [7:0] lit26 [12];
  logic [7:0] csf_hi26, csf_lo26, zero_field;
  int ovf_before, k;

  initial begin
    csf_hi26   = CSUM_ON ? 8'hA1 : 8'h00;
    csf_lo26   = CSUM_ON ? 8'hB2 : 8'h00;
    zero_field = CSUM_ON ? 8'hFF : 8'h00;
    lit26 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0C, csf_hi26, csf_lo26,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_udp_len", udp_len, 0);
    rst_n = 1'b1;

    // Reference frame with fixed ports, checksum and payload.
    ready_mode = 0;
    pay_in = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_frame(16'h1234, 16'h5678, 16'hA1B2, 1'b0, 1'b0);
    wait_frame();
    check("ref_frame_size", got.size(), 12);
    for (int i = 0; i < 12; i++) check("ref_frame_byte", got[i], lit26[i]);

    // One-byte payload straight from IDLE.
    pay_in = '{8'h55};
    load_frame(16'hC001, 16'h0035, 16'h3C4D, 1'b0, 1'b0);
    wait_frame();
    check("one_byte_size", got.size(), 9);
    check("one_byte_len_hi", got[4], 8'h00);
    check("one_byte_len_lo", got[5], 8'h09);
    check("one_byte_payload", got[8], 8'h55);

    // Zero checksum handling.
    pay_in = '{8'h01, 8'h02};
    load_frame(16'h0A0B, 16'h0C0D, 16'h0000, 1'b0, 1'b0);
    wait_frame();
    check("zero_csum_hi", got[6], zero_field);
    check("zero_csum_lo", got[7], zero_field);

    // Ready toggling every cycle.
    ready_mode = 1;
    rand_payload(4);
    load_frame(16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
    wait_frame();
    check("toggle_size", got.size(), 12);

    // Overflow: 10 bytes into an 8-byte buffer.
    ready_mode = 0;
    ovf_before = ovf_seen;
    rand_payload(10);
    load_frame(16'h4444, 16'h5555, 16'h6666, 1'b0, 1'b1);
    wait_frame();
    check("ovf_pulses", ovf_seen - ovf_before, 2);
    check("ovf_frame_size", got.size(), 16);
    check("ovf_len_lo", got[5], 8'h10);

    // Stray byte after the last one is dropped.
    ready_mode = 2;
    rand_payload(3);
    load_frame(16'h7777, 16'h8888, 16'h9999, 1'b1, 1'b0);
    wait_frame();
    check("stray_size", got.size(), 11);

    // Reset while header byte 3 is presented.
    ready_mode = 0;
    rand_payload(5);
    load_frame(16'hABCD, 16'hEF01, 16'h2345, 1'b0, 1'b0);
    k = 0;
    while (got.size() < 3 && k < 200) begin
      @(posedge clk); k++;
    end
    check("reached_hdr3", got.size(), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_en", tx_en, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_last", tx_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_udp_len", udp_len, 0);
    check("midrst_ovf", ovf_err, 0);
    exp_q.delete(); exp_l.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_payload(6);
    load_frame(16'h0102, 16'h0304, 16'h0506, 1'b0, 1'b0);
    wait_frame();
    check("post_rst_size", got.size(), 14);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      ready_mode = $urandom_range(0, 2);
      rand_payload($urandom_range(1, 12));
      load_frame(16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                 1'($urandom_range(0, 1)), 1'b1);
      wait_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
